iomem_rng_fetcher: RTL and testbench
====================================

Name: iomem_rng_fetcher

Overview:
- iomem bus initiator. It drives valid/addr/wstrb/wdata and consumes ready/rdata, so it is the requesting end of the same iomem protocol that the SoC's memory-mapped peripherals answer.
- On a start command it reads COUNT words from the RNG data register at RNG_ADDR, discards "not-ready" sentinel reads and retries them, and buffers accepted words in an internal FIFO.
- A downstream crypto datapath drains the FIFO through a valid/ready stream port.

Parameters:
- RNG_ADDR, 32'h0300_1000, target register address driven on iomem_addr.
- BUSY_WORD, 32'hffff_ffff, sentinel read value meaning "data not ready"; such reads are discarded.
- FIFO_DEPTH, 8, output FIFO entries; power of two, 2..64.
- TIMEOUT, 64, maximum number of cycles valid may stay high without ready before abort; 2..255.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous, active-low reset
- start  in  1  one-cycle pulse; begins a fetch run when idle
- count  in  8  number of words to fetch; sampled on start
- busy  out  1  high while a run is in progress
- done  out  1  one-cycle pulse at the end of a run (normal end or abort)
- timeout_err  out  1  sticky abort flag; cleared by the next accepted start
- iomem_valid  out  1  bus request
- iomem_ready  in  1  bus acknowledge, one cycle wide
- iomem_wstrb  out  4  always 4'b0000 (reads only)
- iomem_addr  out  32  RNG_ADDR while valid is high, 0 otherwise
- iomem_wdata  out  32  always 0
- iomem_rdata  in  32  read data, valid in the cycle ready is high
- out_valid  out  1  FIFO not empty
- out_ready  in  1  consumer accepts out_data
- out_data  out  32  FIFO head word
- fifo_level  out  log2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (resetn=0 at a clk edge): the following outputs are 0: busy, done, timeout_err, iomem_valid, iomem_addr, out_valid, fifo_level.
  - FIFO pointers and the remaining-word counter are cleared.
  - A reset asserted mid-transaction drops valid on the next edge and discards FIFO contents.
- FSM states: IDLE, ISSUE, WAIT, GAP, FINISH.
- IDLE:
  - start=1 with count=0 goes to FINISH; no bus traffic.
  - start=1 with count>0 loads rem=count, clears timeout_err, sets busy, goes to ISSUE.
  - start while busy is ignored.
- ISSUE: when fifo_level + outstanding < FIFO_DEPTH, assert valid, load the timeout counter to 0, go to WAIT. Otherwise stay in ISSUE with valid low (back-pressure).
- WAIT: valid is held high and addr is stable.
  - On ready=1, capture rdata in that same cycle.
  - rdata != BUSY_WORD: push it into the FIFO and decrement rem.
  - rdata == BUSY_WORD: no push; rem is unchanged.
  - In both cases valid drops on the next edge; go to GAP.
  - Timeout: the counter increments each WAIT cycle without ready. At TIMEOUT, drop valid, set timeout_err, go to FINISH; FIFO contents are kept.
- GAP: valid stays low for exactly one cycle, because responders qualify on valid && !ready. Then go to ISSUE if rem>0, else FINISH.
- FINISH: done=1 for one cycle, busy=0, go to IDLE.
- Minimum bus latency per word is 3 cycles: ISSUE, WAIT (with same-cycle ready), GAP.
- A genuine random value equal to BUSY_WORD is dropped by design; this is a known 2^-32 bias and is accepted.
- FIFO behaviour:
  - Push and pop in the same cycle leave fifo_level unchanged.
  - A push never occurs when full; the ISSUE gating guarantees this.
  - Pops with out_valid=0 are ignored.
  - Pointers wrap modulo FIFO_DEPTH.
  - out_data is registered head data and is valid whenever out_valid=1.
- The consumer may drain the FIFO at any time, including while idle and after an abort.

Test Plan:
- Basic run: start with count=3, responder gives ready one cycle after valid with data 0x11,0x22,0x33. Required: three pushes, FIFO drains in order 0x11,0x22,0x33, done pulses once, busy falls with done, and each valid low gap is exactly 1 cycle.
- Sentinel retry: count=2, responder returns 0xffff_ffff, 0xA5A5_0001, 0xffff_ffff, 0x5A5A_0002. Required: 4 bus reads, FIFO holds only 0xA5A5_0001 and 0x5A5A_0002, wstrb=0 on every read.
- Back-pressure: FIFO_DEPTH=8, count=12, out_ready=0. Required: fetching stalls at fifo_level=8 with valid low. Raising out_ready resumes fetching; all 12 words are delivered in order and fifo_level never exceeds 8.
- Timeout: responder never asserts ready, TIMEOUT=64. Required: valid stays high for 64 cycles then drops, timeout_err=1, done pulses. A subsequent start clears timeout_err.
- Edge commands: count=0 start gives done one cycle after start with valid never asserted. A start pulse during busy is ignored and the word count is unchanged.
- Reset mid-transfer: resetn=0 while in WAIT with 3 words buffered. Required: next edge has valid=0, fifo_level=0, busy=0, out_valid=0, and no done pulse.

Source files
------------

// File: rtl/iomem_rng_fetcher.sv
// rtl/iomem_rng_fetcher.sv - iomem bus initiator that fetches RNG words into a stream FIFO
//
// Purpose: on start, reads `count` non-sentinel words from the RNG data
// register over iomem, retrying reads that return BUSY_WORD, and buffers the
// accepted words in a small FIFO drained through a valid/ready stream port.
//
// Ports:
//   clk, resetn         clock, synchronous active-low reset
//   start, count        run request pulse and word count (sampled when idle)
//   busy, done          run in progress / one-cycle end-of-run pulse
//   timeout_err         sticky abort flag, cleared by the next accepted start
//   iomem_*             initiator side of the iomem bus (reads only)
//   out_valid/ready     FIFO head handshake, out_data = head word
//   fifo_level          current FIFO occupancy
module iomem_rng_fetcher #(
  parameter logic [31:0] RNG_ADDR   = 32'h0300_1000,
  parameter logic [31:0] BUSY_WORD  = 32'hffff_ffff,
  parameter int          FIFO_DEPTH = 8,
  parameter int          TIMEOUT    = 64
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          start,
  input  logic [7:0]                    count,
  output logic                          busy,
  output logic                          done,
  output logic                          timeout_err,
  output logic                          iomem_valid,
  input  logic                          iomem_ready,
  output logic [3:0]                    iomem_wstrb,
  output logic [31:0]                   iomem_addr,
  output logic [31:0]                   iomem_wdata,
  input  logic [31:0]                   iomem_rdata,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [31:0]                   out_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int              AW      = $clog2(FIFO_DEPTH);
  localparam int              LW      = AW + 1;
  localparam logic [LW-1:0]   DEPTH_L = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0]   LVL_ONE = LW'(1);
  localparam logic [AW-1:0]   PTR_ONE = AW'(1);
  // Valid is already high during ISSUE, so the abort fires after TIMEOUT-1
  // unanswered WAIT cycles, giving exactly TIMEOUT cycles of valid.
  localparam logic [7:0]      TO_LAST = 8'(TIMEOUT - 2);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, GAP, FINISH} state_t;

  state_t          state, state_nxt;
  logic [7:0]      rem;
  logic [7:0]      tcnt;
  logic [31:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic            load_run, push, pop, abort;

  // Only one read is ever in flight, and none is outstanding while in ISSUE,
  // so room for one more word is simply level < depth.
  logic has_room;
  assign has_room = (fifo_level < DEPTH_L);

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    busy        = 1'b0;
    done        = 1'b0;
    iomem_valid = 1'b0;
    load_run    = 1'b0;
    push        = 1'b0;
    abort       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load_run  = 1'b1;
          state_nxt = (count == 8'd0) ? FINISH : ISSUE;
        end
      end
      ISSUE: begin
        busy = 1'b1;
        if (has_room) begin
          iomem_valid = 1'b1;
          state_nxt   = WAIT;
        end
      end
      WAIT: begin
        busy        = 1'b1;
        iomem_valid = 1'b1;
        if (iomem_ready) begin
          push      = (iomem_rdata != BUSY_WORD);
          state_nxt = GAP;
        end else if (tcnt == TO_LAST) begin
          abort     = 1'b1;
          state_nxt = FINISH;
        end
      end
      GAP: begin
        busy      = 1'b1;
        state_nxt = (rem != 8'd0) ? ISSUE : FINISH;
      end
      FINISH: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign pop         = out_ready && out_valid;
  assign out_valid   = (fifo_level != '0);
  assign out_data    = mem[rd_ptr];
  assign iomem_addr  = iomem_valid ? RNG_ADDR : 32'd0;
  assign iomem_wstrb = 4'b0000;
  assign iomem_wdata = 32'd0;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rem         <= 8'd0;
      tcnt        <= 8'd0;
      timeout_err <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_level  <= '0;
    end else begin
      if (load_run) begin
        rem         <= count;
        timeout_err <= 1'b0;
      end else if (push) begin
        rem <= rem - 8'd1;
      end

      if (abort) timeout_err <= 1'b1;

      if (state == ISSUE)                      tcnt <= 8'd0;
      else if (state == WAIT && !iomem_ready)  tcnt <= tcnt + 8'd1;

      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;

      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LVL_ONE;
        2'b01:   fifo_level <= fifo_level - LVL_ONE;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible once pointers advance.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= iomem_rdata;
  end

endmodule

// File: tb/tb_iomem_rng_fetcher.sv
// tb/tb_iomem_rng_fetcher.sv - self-checking bench for iomem_rng_fetcher
module tb_iomem_rng_fetcher;

  localparam logic [31:0] RNG_ADDR   = 32'h0300_1000;
  localparam logic [31:0] BUSY_WORD  = 32'hffff_ffff;
  localparam int          FIFO_DEPTH = 8;
  localparam int          TIMEOUT    = 64;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  count = 8'd0;
  logic        busy, done, timeout_err, iomem_valid;
  logic        iomem_ready = 1'b0;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr, iomem_wdata;
  logic [31:0] iomem_rdata = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [3:0]  fifo_level;

  iomem_rng_fetcher #(
    .RNG_ADDR(RNG_ADDR), .BUSY_WORD(BUSY_WORD),
    .FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .resetn(resetn), .start(start), .count(count),
    .busy(busy), .done(done), .timeout_err(timeout_err),
    .iomem_valid(iomem_valid), .iomem_ready(iomem_ready),
    .iomem_wstrb(iomem_wstrb), .iomem_addr(iomem_addr),
    .iomem_wdata(iomem_wdata), .iomem_rdata(iomem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference model: the word stream the consumer must see is exactly the
  // responder's non-sentinel words, in the order they were returned.
  logic [31:0] resp_q[$];
  logic [31:0] exp_q[$];
  bit resp_hang = 1'b0;
  int lat_min = 1, lat_max = 1, resp_lat = 1, resp_seen = 0;
  int busy_pct = 0;
  int bus_reads = 0;

  initial begin : responder
    logic [31:0] w;
    forever begin
      @(negedge clk);
      iomem_ready = 1'b0;
      if (!iomem_valid) begin
        resp_seen = 0;
      end else if (!resp_hang) begin
        if (resp_seen >= resp_lat) begin
          if (resp_q.size() > 0) w = resp_q.pop_front();
          else if (int'($urandom_range(99)) < busy_pct) w = BUSY_WORD;
          else begin
            w = $urandom;
            if (w == BUSY_WORD) w = 32'd0;
          end
          iomem_ready = 1'b1;
          iomem_rdata = w;
          bus_reads++;
          if (w != BUSY_WORD) exp_q.push_back(w);
          resp_seen = 0;
          resp_lat = int'($urandom_range(lat_max, lat_min));
        end else begin
          resp_seen++;
        end
      end
    end
  end

  int drain_mode = 0;
  int popped = 0;

  initial begin : consumer
    logic [31:0] e;
    forever begin
      @(negedge clk);
      case (drain_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = ($urandom_range(1) == 1);
      endcase
      if (out_ready && out_valid) begin
        popped++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : ~out_data;
        check("pop_data", out_data, e);
      end
    end
  end

  int done_pulses = 0, level_max = 0, bus_viol = 0;
  int gap_min = 1000, gap_max = 0, low_run = 0, high_run = 0, last_high = 0;

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (done) done_pulses++;
      if (int'(fifo_level) > level_max) level_max = int'(fifo_level);
      if (iomem_wstrb != 4'd0 || iomem_wdata != 32'd0) bus_viol++;
      if (iomem_valid ? (iomem_addr != RNG_ADDR) : (iomem_addr != 32'd0)) bus_viol++;
      if (iomem_valid) begin
        if (low_run > 0) begin
          if (low_run < gap_min) gap_min = low_run;
          if (low_run > gap_max) gap_max = low_run;
        end
        low_run = 0;
        high_run++;
      end else begin
        if (high_run > 0) last_high = high_run;
        high_run = 0;
        low_run = busy ? low_run + 1 : 0;
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic pulse_start(input logic [7:0] c);
    count = c;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic clear_stats();
    bus_reads = 0; done_pulses = 0; bus_viol = 0; popped = 0;
    gap_min = 1000; gap_max = 0; level_max = 0;
  endtask

  task automatic wait_done(input string tag, input int budget, input bit chk_busy);
    int n = 0;
    logic prev_busy = busy;
    while (!done && n < budget) begin
      prev_busy = busy;
      step();
      n++;
    end
    check({tag, "_done_seen"}, done, 1'b1);
    if (chk_busy) begin
      check({tag, "_busy_before_done"}, prev_busy, 1'b1);
      check({tag, "_busy_at_done"}, busy, 1'b0);
    end
  endtask

  task automatic drain_all(input string tag);
    int n = 0;
    drain_mode = 1;
    while (fifo_level != 4'd0 && n < 200) begin
      step();
      n++;
    end
    drain_mode = 0;
    step();
    check({tag, "_drained_level"}, fifo_level, 4'd0);
    check({tag, "_model_empty"}, exp_q.size(), 0);
  endtask

  initial begin : main
    int n;
    int dpb;
    int rb;

    // Reset state
    resetn = 1'b0;
    step(3);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_timeout_err", timeout_err, 1'b0);
    check("rst_valid", iomem_valid, 1'b0);
    check("rst_addr", iomem_addr, 32'd0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_level", fifo_level, 4'd0);
    resetn = 1'b1;
    step(2);

    // Basic run
    clear_stats();
    resp_q = '{32'h11, 32'h22, 32'h33};
    lat_min = 1; lat_max = 1; resp_lat = 1; busy_pct = 0;
    pulse_start(8'd3);
    wait_done("basic", 100, 1'b1);
    step(2);
    check("basic_reads", bus_reads, 3);
    check("basic_level", fifo_level, 4'd3);
    check("basic_done_pulses", done_pulses, 1);
    check("basic_gap_min", gap_min, 1);
    check("basic_gap_max", gap_max, 1);
    check("basic_head", out_data, 32'h11);
    drain_all("basic");

    // Sentinel retry
    clear_stats();
    resp_q = '{32'hffff_ffff, 32'ha5a5_0001, 32'hffff_ffff, 32'h5a5a_0002};
    pulse_start(8'd2);
    wait_done("sent", 100, 1'b1);
    step();
    check("sent_reads", bus_reads, 4);
    check("sent_level", fifo_level, 4'd2);
    check("sent_bus_viol", bus_viol, 0);
    check("sent_gap_max", gap_max, 1);
    drain_all("sent");
    check("sent_popped", popped, 2);

    // Back-pressure
    clear_stats();
    lat_min = 1; lat_max = 3; busy_pct = 20;
    pulse_start(8'd12);
    n = 0;
    while (fifo_level != 4'd8 && n < 400) begin step(); n++; end
    step(10);
    check("bp_stall_level", fifo_level, 4'd8);
    check("bp_stall_valid", iomem_valid, 1'b0);
    check("bp_stall_busy", busy, 1'b1);
    drain_mode = 2;
    wait_done("bp", 2000, 1'b1);
    drain_all("bp");
    check("bp_level_max", level_max, 8);
    check("bp_popped", popped, 12);
    check("bp_bus_viol", bus_viol, 0);

    // Timeout
    clear_stats();
    resp_hang = 1'b1;
    pulse_start(8'd2);
    wait_done("to", 300, 1'b1);
    check("to_err_set", timeout_err, 1'b1);
    check("to_valid_high_cycles", last_high, TIMEOUT);
    check("to_valid_dropped", iomem_valid, 1'b0);
    step(3);
    check("to_done_pulses", done_pulses, 1);
    check("to_err_sticky", timeout_err, 1'b1);
    resp_hang = 1'b0; busy_pct = 0; lat_min = 1; lat_max = 1; resp_lat = 1;
    pulse_start(8'd1);
    check("to_err_cleared", timeout_err, 1'b0);
    wait_done("to_rerun", 100, 1'b1);
    drain_all("to_rerun");

    // count = 0
    clear_stats();
    pulse_start(8'd0);
    check("zero_done", done, 1'b1);
    check("zero_valid", iomem_valid, 1'b0);
    step();
    check("zero_done_cleared", done, 1'b0);
    check("zero_reads", bus_reads, 0);

    // Start while busy is ignored
    clear_stats();
    lat_min = 2; lat_max = 2; resp_lat = 2;
    pulse_start(8'd3);
    step(2);
    pulse_start(8'd7);
    wait_done("ign", 200, 1'b1);
    step();
    check("ign_reads", bus_reads, 3);
    check("ign_level", fifo_level, 4'd3);
    check("ign_done_pulses", done_pulses, 1);
    drain_all("ign");

    // Randomized runs
    for (int r = 0; r < 8; r++) begin
      logic [7:0] c;
      clear_stats();
      c = 8'($urandom_range(20, 1));
      lat_min = 1;
      lat_max = int'($urandom_range(4, 1));
      resp_lat = 1;
      busy_pct = int'($urandom_range(40));
      drain_mode = int'($urandom_range(2, 1));
      pulse_start(c);
      wait_done("rnd", 4000, 1'b1);
      drain_all("rnd");
      check("rnd_popped", popped, int'(c));
      check("rnd_no_timeout", timeout_err, 1'b0);
      check("rnd_level_max_ok", (level_max <= FIFO_DEPTH), 1'b1);
      check("rnd_bus_viol", bus_viol, 0);
    end

    // Reset in WAIT with three words buffered
    clear_stats();
    lat_min = 1; lat_max = 1; resp_lat = 1; busy_pct = 0;
    pulse_start(8'd6);
    n = 0;
    while (fifo_level != 4'd3 && n < 100) begin step(); n++; end
    resp_hang = 1'b1;
    step(2);
    check("rstmid_in_wait", iomem_valid, 1'b1);
    check("rstmid_level_pre", fifo_level, 4'd3);
    dpb = done_pulses;
    rb = bus_reads;
    resetn = 1'b0;
    step();
    check("rstmid_valid", iomem_valid, 1'b0);
    check("rstmid_level", fifo_level, 4'd0);
    check("rstmid_busy", busy, 1'b0);
    check("rstmid_out_valid", out_valid, 1'b0);
    check("rstmid_done", done, 1'b0);
    resetn = 1'b1;
    exp_q.delete();
    resp_hang = 1'b0;
    step(5);
    check("rstmid_no_done", done_pulses, dpb);
    check("rstmid_no_reads", bus_reads, rb);
    check("rstmid_idle", busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
